id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Pipeline register between decode/register-file read and the ALU.
- Captures decoded operands and control on each clock edge, then drives the ALU operand buses N1/N2 and ALUctrl.
- Operands pass through combinational forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, inserts bubbles on detection or flush, and holds its contents on stall.

Parameters:
- W, 32, datapath width in bits.
- RA, 5, register address width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold all stage contents
- flush  in  1  replace the captured instruction with a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  W  PC of the decode instruction
- id_rs1_addr  in  RA  source register 1 address
- id_rs2_addr  in  RA  source register 2 address
- id_rd_addr  in  RA  destination register address
- id_rs1_data  in  W  register-file read data for rs1
- id_rs2_data  in  W  register-file read data for rs2
- id_imm  in  W  sign-extended immediate
- id_ALUctrl  in  3  ALU operation code
- id_ALUsrc  in  1  1 selects immediate as N2
- id_RegWrite  in  1  instruction writes rd
- id_MemRead  in  1  instruction is a load
- id_MemWrite  in  1  instruction is a store
- id_Branch  in  1  instruction is a branch
- exm_rd  in  RA  EX/MEM destination register
- exm_RegWrite  in  1  EX/MEM will write exm_rd
- exm_result  in  W  EX/MEM ALU result
- mwb_rd  in  RA  MEM/WB destination register
- mwb_RegWrite  in  1  MEM/WB will write mwb_rd
- mwb_result  in  W  MEM/WB writeback value
- ld_use_stall  out  1  request to stall PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc  out  W  registered PC
- ALUctrl  out  3  to ALU
- N1  out  W  ALU operand 1
- N2  out  W  ALU operand 2
- ex_store_data  out  W  forwarded rs2 value, for stores
- ex_rd_addr  out  RA  registered rd
- ex_RegWrite  out  1  registered control, gated by ex_valid
- ex_MemRead  out  1  registered control, gated by ex_valid
- ex_MemWrite  out  1  registered control, gated by ex_valid
- ex_Branch  out  1  registered control, gated by ex_valid

Behaviour:
- Registered state: valid, pc, rs1/rs2 addresses, rs1/rs2 data, imm, rd, ALUctrl, ALUsrc, RegWrite, MemRead, MemWrite, Branch.
- Reset: every registered field is 0. This gives ex_valid=0, all ex_* controls 0, ALUctrl=000, N1=N2=0, ex_store_data=0.
- Per-edge update priority: rst > flush > stall > ld_use_stall > load.
  - flush: load a bubble. valid=0, all controls 0, ALUctrl=000, data fields 0.
  - stall (no flush): hold every field unchanged.
  - ld_use_stall (no stall, no flush): load a bubble. Upstream holds the decode instruction, so it re-presents on the next cycle.
  - Otherwise: load all id_* fields. id_valid=0 loads a bubble.
- Latency: one cycle from id_* to ex_*.
- Forwarding and operand outputs are combinational on registered state plus the current exm_*/mwb_* inputs.
- Forwarded operand fwdX, for X in rs1 and rs2:
  - address 0 → 0, never forwarded; x0 reads as zero.
  - else if exm_RegWrite and exm_rd == addr → exm_result.
  - else if mwb_RegWrite and mwb_rd == addr → mwb_result.
  - else → registered data.
- EX/MEM forwarding has priority when both stages match.
- Operand outputs:
  - N1 = fwd1.
  - N2 = ALUsrc ? imm : fwd2.
  - ex_store_data = fwd2, regardless of ALUsrc.
- Forwarding is evaluated every cycle, including during stall. A held instruction therefore picks up newer results as they arrive.
- ld_use_stall = valid & MemRead & (ex_rd_addr != 0) & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr) & id_valid.
- ld_use_stall is combinational. The rs2 compare is conservative and also fires for I-type instructions.
- Bubble output: ex_valid=0 forces ex_RegWrite, ex_MemRead, ex_MemWrite and ex_Branch to 0 at the outputs.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall: state clears on that edge.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with id_valid=0 → all outputs 0, ld_use_stall=0.
- Basic load: id_rs1=x1 (data 5), id_rs2=x2 (data 7), ALUctrl=001, ALUsrc=0, no forwarding match → next cycle N1=5, N2=7, ALUctrl=001, ex_valid=1.
- Immediate select: same as basic load with ALUsrc=1, imm=0xFFFFFFFC → N2=0xFFFFFFFC, ex_store_data=7.
- Forward priority: registered rs1=x3; exm_rd=3, exm_result=0x10; mwb_rd=3, mwb_result=0x20; both RegWrite=1 → N1=0x10. Drop exm_RegWrite → N1=0x20. With rs1 address 0 and exm_rd=0 → N1=0.
- Load-use: EX holds a load with rd=x4; decode presents rs2=x4, id_valid=1 → ld_use_stall=1. Next cycle ex_valid=0, ex_RegWrite=0. Re-present the instruction with the load now in MEM/WB forwarding → N2=mwb_result.
- Stall/flush: stall=1 for 3 cycles while id_* inputs change → ex_* unchanged. stall=1 and flush=1 together → bubble. rst=1 during stall → cleared next edge.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// forwards from EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles.
module id_ex_operand_stage #(
   parameter int W  = 32,
   parameter int RA = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [W-1:0]  id_pc,
   input  logic [RA-1:0] id_rs1_addr,
   input  logic [RA-1:0] id_rs2_addr,
   input  logic [RA-1:0] id_rd_addr,
   input  logic [W-1:0]  id_rs1_data,
   input  logic [W-1:0]  id_rs2_data,
   input  logic [W-1:0]  id_imm,
   input  logic [2:0]    id_ALUctrl,
   input  logic          id_ALUsrc,
   input  logic          id_RegWrite,
   input  logic          id_MemRead,
   input  logic          id_MemWrite,
   input  logic          id_Branch,
   input  logic [RA-1:0] exm_rd,
   input  logic          exm_RegWrite,
   input  logic [W-1:0]  exm_result,
   input  logic [RA-1:0] mwb_rd,
   input  logic          mwb_RegWrite,
   input  logic [W-1:0]  mwb_result,
   output logic          ld_use_stall,
   output logic          ex_valid,
   output logic [W-1:0]  ex_pc,
   output logic [2:0]    ALUctrl,
   output logic [W-1:0]  N1,
   output logic [W-1:0]  N2,
   output logic [W-1:0]  ex_store_data,
   output logic [RA-1:0] ex_rd_addr,
   output logic          ex_RegWrite,
   output logic          ex_MemRead,
   output logic          ex_MemWrite,
   output logic          ex_Branch
);

   logic          valid_r;
   logic [W-1:0]  pc_r;
   logic [RA-1:0] rs1_addr_r;
   logic [RA-1:0] rs2_addr_r;
   logic [W-1:0]  rs1_data_r;
   logic [W-1:0]  rs2_data_r;
   logic [W-1:0]  imm_r;
   logic [RA-1:0] rd_r;
   logic [2:0]    alu_ctrl_r;
   logic          alu_src_r;
   logic          reg_write_r;
   logic          mem_read_r;
   logic          mem_write_r;
   logic          branch_r;

   logic          ld_use_s;
   logic [W-1:0]  fwd1_s;
   logic [W-1:0]  fwd2_s;

   // x0 is never forwarded; the younger EX/MEM result beats MEM/WB.
   function automatic logic [W-1:0] forward(
      input logic [RA-1:0] addr,
      input logic [W-1:0]  reg_data,
      input logic [RA-1:0] e_rd,
      input logic          e_we,
      input logic [W-1:0]  e_val,
      input logic [RA-1:0] m_rd,
      input logic          m_we,
      input logic [W-1:0]  m_val
   );
      logic [W-1:0] result;
      if (addr == {RA{1'b0}}) begin
         result = {W{1'b0}};
      end else if (e_we && (e_rd == addr)) begin
         result = e_val;
      end else if (m_we && (m_rd == addr)) begin
         result = m_val;
      end else begin
         result = reg_data;
      end
      return result;
   endfunction

   // Hazard detection and operand forwarding on the registered instruction.
   always_comb begin
      ld_use_s = 1'b0;
      fwd1_s   = {W{1'b0}};
      fwd2_s   = {W{1'b0}};
      if (valid_r && mem_read_r && (rd_r != {RA{1'b0}}) && id_valid &&
          ((rd_r == id_rs1_addr) || (rd_r == id_rs2_addr))) begin
         ld_use_s = 1'b1;
      end else begin
         ld_use_s = 1'b0;
      end
      fwd1_s = forward(rs1_addr_r, rs1_data_r, exm_rd, exm_RegWrite, exm_result,
                       mwb_rd, mwb_RegWrite, mwb_result);
      fwd2_s = forward(rs2_addr_r, rs2_data_r, exm_rd, exm_RegWrite, exm_result,
                       mwb_rd, mwb_RegWrite, mwb_result);
   end

   // Stage register: reset/flush/load-use/invalid decode all load a bubble; stall holds.
   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && (ld_use_s || !id_valid))) begin
         valid_r     <= 1'b0;
         pc_r        <= {W{1'b0}};
         rs1_addr_r  <= {RA{1'b0}};
         rs2_addr_r  <= {RA{1'b0}};
         rs1_data_r  <= {W{1'b0}};
         rs2_data_r  <= {W{1'b0}};
         imm_r       <= {W{1'b0}};
         rd_r        <= {RA{1'b0}};
         alu_ctrl_r  <= 3'b000;
         alu_src_r   <= 1'b0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         branch_r    <= 1'b0;
      end else if (stall) begin
         valid_r     <= valid_r;
         pc_r        <= pc_r;
         rs1_addr_r  <= rs1_addr_r;
         rs2_addr_r  <= rs2_addr_r;
         rs1_data_r  <= rs1_data_r;
         rs2_data_r  <= rs2_data_r;
         imm_r       <= imm_r;
         rd_r        <= rd_r;
         alu_ctrl_r  <= alu_ctrl_r;
         alu_src_r   <= alu_src_r;
         reg_write_r <= reg_write_r;
         mem_read_r  <= mem_read_r;
         mem_write_r <= mem_write_r;
         branch_r    <= branch_r;
      end else begin
         valid_r     <= 1'b1;
         pc_r        <= id_pc;
         rs1_addr_r  <= id_rs1_addr;
         rs2_addr_r  <= id_rs2_addr;
         rs1_data_r  <= id_rs1_data;
         rs2_data_r  <= id_rs2_data;
         imm_r       <= id_imm;
         rd_r        <= id_rd_addr;
         alu_ctrl_r  <= id_ALUctrl;
         alu_src_r   <= id_ALUsrc;
         reg_write_r <= id_RegWrite;
         mem_read_r  <= id_MemRead;
         mem_write_r <= id_MemWrite;
         branch_r    <= id_Branch;
      end
   end

   assign ld_use_stall  = ld_use_s;
   assign ex_valid      = valid_r;
   assign ex_pc         = pc_r;
   assign ALUctrl       = alu_ctrl_r;
   assign N1            = fwd1_s;
   assign N2            = alu_src_r ? imm_r : fwd2_s;
   assign ex_store_data = fwd2_s;
   assign ex_rd_addr    = rd_r;
   assign ex_RegWrite   = valid_r & reg_write_r;
   assign ex_MemRead    = valid_r & mem_read_r;
   assign ex_MemWrite   = valid_r & mem_write_r;
   assign ex_Branch     = valid_r & branch_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, load, immediate select, forwarding,
// load-use bubble, stall hold, flush priority and reset during stall.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [2:0]  id_ALUctrl;
   logic        id_ALUsrc, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
   logic [4:0]  exm_rd, mwb_rd;
   logic        exm_RegWrite, mwb_RegWrite;
   logic [31:0] exm_result, mwb_result;
   logic        ld_use_stall, ex_valid;
   logic [31:0] ex_pc, N1, N2, ex_store_data;
   logic [2:0]  ALUctrl;
   logic [4:0]  ex_rd_addr;
   logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;

   int tests = 0;
   int failed = 0;

   id_ex_operand_stage #(.W(32), .RA(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_ALUctrl(id_ALUctrl), .id_ALUsrc(id_ALUsrc),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_Branch(id_Branch), .exm_rd(exm_rd), .exm_RegWrite(exm_RegWrite),
      .exm_result(exm_result), .mwb_rd(mwb_rd), .mwb_RegWrite(mwb_RegWrite),
      .mwb_result(mwb_result), .ld_use_stall(ld_use_stall), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ALUctrl(ALUctrl), .N1(N1), .N2(N2), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      id_pc = 32'h0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
      id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = 32'h0; id_ALUctrl = 3'b000;
      id_ALUsrc = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0;
      id_Branch = 1'b0; exm_rd = 5'd0; exm_RegWrite = 1'b0; exm_result = 32'h0;
      mwb_rd = 5'd0; mwb_RegWrite = 1'b0; mwb_result = 32'h0;

      // reset
      tick(); tick();
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_N1", N1, 32'h0);
      rst = 1'b0;
      tick();
      check("rel_valid", {31'd0, ex_valid}, 32'd0);
      check("rel_ctrl", {28'd0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch}, 32'd0);
      check("rel_alu", {29'd0, ALUctrl}, 32'd0);
      check("rel_N2", N2, 32'h0);
      check("rel_store", ex_store_data, 32'h0);
      check("rel_lduse", {31'd0, ld_use_stall}, 32'd0);

      // basic load
      id_valid = 1'b1; id_pc = 32'h100; id_rs1_addr = 5'd1; id_rs1_data = 32'd5;
      id_rs2_addr = 5'd2; id_rs2_data = 32'd7; id_rd_addr = 5'd5; id_ALUctrl = 3'b001;
      id_RegWrite = 1'b1; id_Branch = 1'b1;
      tick();
      check("basic_N1", N1, 32'd5);
      check("basic_N2", N2, 32'd7);
      check("basic_alu", {29'd0, ALUctrl}, 32'd1);
      check("basic_valid", {31'd0, ex_valid}, 32'd1);
      check("basic_pc", ex_pc, 32'h100);
      check("basic_rd", {27'd0, ex_rd_addr}, 32'd5);
      check("basic_ctrl", {28'd0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch}, 32'b1001);

      // immediate select
      id_ALUsrc = 1'b1; id_imm = 32'hFFFF_FFFC; id_Branch = 1'b0;
      tick();
      check("imm_N2", N2, 32'hFFFF_FFFC);
      check("imm_store", ex_store_data, 32'd7);
      check("imm_N1", N1, 32'd5);

      // forwarding priority on rs1
      id_ALUsrc = 1'b0; id_rs1_addr = 5'd3; id_rs1_data = 32'h99;
      tick();
      check("fwd_none", N1, 32'h99);
      exm_rd = 5'd3; exm_result = 32'h10; exm_RegWrite = 1'b1;
      mwb_rd = 5'd3; mwb_result = 32'h20; mwb_RegWrite = 1'b1;
      #1 check("fwd_exm_prio", N1, 32'h10);
      exm_RegWrite = 1'b0;
      #1 check("fwd_mwb", N1, 32'h20);

      // x0 never forwarded; rs2 forwards into store data but not into imm-selected N2
      id_rs1_addr = 5'd0; id_rs1_data = 32'h55; id_rs2_addr = 5'd2; id_ALUsrc = 1'b1;
      id_imm = 32'd4;
      tick();
      exm_rd = 5'd0; exm_RegWrite = 1'b1; mwb_rd = 5'd2; mwb_RegWrite = 1'b1;
      #1 check("fwd_x0", N1, 32'h0);
      check("fwd_imm_N2", N2, 32'd4);
      check("fwd_store", ex_store_data, 32'h20);

      // load-use: load x4 into EX
      exm_RegWrite = 1'b0; mwb_RegWrite = 1'b0;
      id_pc = 32'h200; id_rs1_addr = 5'd1; id_rs2_addr = 5'd0; id_rd_addr = 5'd4;
      id_MemRead = 1'b1; id_RegWrite = 1'b1; id_ALUsrc = 1'b1;
      tick();
      check("ld_memread", {31'd0, ex_MemRead}, 32'd1);
      id_pc = 32'h300; id_rs1_addr = 5'd6; id_rs1_data = 32'd6; id_rs2_addr = 5'd4;
      id_rs2_data = 32'h77; id_rd_addr = 5'd8; id_MemRead = 1'b0; id_ALUsrc = 1'b0;
      id_ALUctrl = 3'b010; id_valid = 1'b0;
      #1 check("lduse_invalid", {31'd0, ld_use_stall}, 32'd0);
      id_valid = 1'b1;
      #1 check("lduse_hit", {31'd0, ld_use_stall}, 32'd1);
      tick();
      check("lduse_bubble", {31'd0, ex_valid}, 32'd0);
      check("lduse_bub_ctrl", {30'd0, ex_RegWrite, ex_MemRead}, 32'd0);
      check("lduse_clear", {31'd0, ld_use_stall}, 32'd0);
      mwb_rd = 5'd4; mwb_RegWrite = 1'b1; mwb_result = 32'hABCD;
      tick();
      check("lduse_rep_valid", {31'd0, ex_valid}, 32'd1);
      check("lduse_rep_N2", N2, 32'hABCD);
      check("lduse_rep_alu", {29'd0, ALUctrl}, 32'd2);

      // stall holds for 3 cycles while decode changes
      stall = 1'b1;
      id_pc = 32'h500; id_rs1_addr = 5'd7; id_rs1_data = 32'h1234; id_ALUctrl = 3'b111;
      id_rs2_addr = 5'd9; id_rd_addr = 5'd10;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", ex_pc, 32'h300);
         check("stall_alu", {29'd0, ALUctrl}, 32'd2);
         check("stall_rd", {27'd0, ex_rd_addr}, 32'd8);
      end
      mwb_result = 32'hBEEF;
      #1 check("stall_fwd", N2, 32'hBEEF);

      // stall and flush together: flush wins
      flush = 1'b1;
      tick();
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      check("flush_pc", ex_pc, 32'h0);
      check("flush_alu", {29'd0, ALUctrl}, 32'd0);
      check("flush_ctrl", {28'd0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch}, 32'd0);

      // reload, then reset asserted during stall
      flush = 1'b0; stall = 1'b0; mwb_RegWrite = 1'b0;
      tick();
      check("reload_valid", {31'd0, ex_valid}, 32'd1);
      check("reload_N1", N1, 32'h1234);
      stall = 1'b1; rst = 1'b1;
      tick();
      check("rststall_valid", {31'd0, ex_valid}, 32'd0);
      check("rststall_pc", ex_pc, 32'h0);
      check("rststall_N1", N1, 32'h0);
      check("rststall_N2", N2, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
